load_store_unit: RTL and testbench

Byte-lane load/store unit between the register-file/ALU datapath and data memory. Accepts one access per request (address from ALUResult, store data from RS2), drives a word-addressed memory port with byte enables, and returns sign- or zero-extended load data for the write-back mux (ReadData). A 4-state FSM holds the access until memory completes, and `req_ready` stalls the controller meanwhile.

---
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-lane load/store unit: one access at a time, byte enables on a word-addressed memory port.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [NBITS-1:0] req_addr,
  input  logic [NBITS-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [NBITS-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             mem_write,
  output logic [NBITS-3:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_rvalid
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRd, StResp} state_t;

  state_t     state;
  logic [1:0] size_q;
  logic       unsigned_q;
  logic [1:0] lane_q;

  logic [NBITS-1:0] st_wdata;
  logic [3:0]       st_be;
  logic             misalign;

  always_comb begin
    st_wdata = req_wdata;
    st_be    = 4'b1111;
    case (req_size)
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_be    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = req_wdata;
        st_be    = 4'b1111;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Select the addressed lane(s) from the read word and extend to full width.
  function automatic logic [NBITS-1:0] extend_load(input logic [NBITS-1:0] word,
                                                   input logic [1:0] size,
                                                   input logic [1:0] lane,
                                                   input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   extend_load = uns ? {{(NBITS-8){1'b0}}, b} : {{(NBITS-8){b[7]}}, b};
      2'b01:   extend_load = uns ? {{(NBITS-16){1'b0}}, h} : {{(NBITS-16){h[15]}}, h};
      default: extend_load = word;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_valid  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= 4'b0000;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      lane_q     <= 2'b00;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            lane_q     <= req_addr[1:0];
            req_ready  <= 1'b0;
            if (misalign) begin
              state     <= StResp;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= StReq;
              mem_valid <= 1'b1;
              mem_write <= req_write;
              mem_addr  <= req_addr[NBITS-1:2];
              mem_wdata <= st_wdata;
              mem_be    <= req_write ? st_be : 4'b1111;
            end
          end
        end
        StReq: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_write) begin
              state     <= StResp;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b0;
            end else begin
              state <= StWaitRd;
            end
          end
        end
        StWaitRd: begin
          if (mem_rvalid) begin
            state     <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= extend_load(mem_rdata, size_q, lane_q, unsigned_q);
            rsp_err   <= 1'b0;
          end
        end
        StResp: begin
          state     <= StIdle;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; samples outputs 1 time unit after each edge.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.NBITS(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    tick();
    req_valid = 1'b0;
  endtask

  // Store with mem_ready held high: response observed one edge after the request edge.
  task automatic run_store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_wd,
                           input logic [3:0] exp_be);
    mem_ready = 1'b1;
    issue(1'b1, sz, 1'b0, addr, wd);
    check({tag, ".mem_valid"}, {31'b0, mem_valid}, 32'd1);
    check({tag, ".mem_write"}, {31'b0, mem_write}, 32'd1);
    check({tag, ".mem_addr"}, {2'b0, mem_addr}, addr >> 2);
    check({tag, ".mem_be"}, {28'b0, mem_be}, {28'b0, exp_be});
    check({tag, ".mem_wdata"}, mem_wdata, exp_wd);
    check({tag, ".req_ready"}, {31'b0, req_ready}, 32'd0);
    check({tag, ".rsp_early"}, {31'b0, rsp_valid}, 32'd0);
    tick();
    check({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, ".mem_drop"}, {31'b0, mem_valid}, 32'd0);
    tick();
    check({tag, ".rsp_pulse"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, ".ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  // Load with mem_ready high at the first REQ edge and mem_rvalid at the next edge.
  task automatic run_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] rd,
                          input logic [31:0] exp);
    mem_ready = 1'b1;
    issue(1'b0, sz, uns, addr, 32'h0);
    check({tag, ".mem_valid"}, {31'b0, mem_valid}, 32'd1);
    check({tag, ".mem_write"}, {31'b0, mem_write}, 32'd0);
    check({tag, ".mem_addr"}, {2'b0, mem_addr}, addr >> 2);
    check({tag, ".mem_be"}, {28'b0, mem_be}, 32'hF);
    tick();
    check({tag, ".wait_rsp"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, ".wait_mem"}, {31'b0, mem_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
    check({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, ".rsp_rdata"}, rsp_rdata, exp);
    check({tag, ".rsp_err"}, {31'b0, rsp_err}, 32'd0);
    tick();
    check({tag, ".rsp_pulse"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, ".ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    tick();
    tick();
    check("rst.req_ready", {31'b0, req_ready}, 32'd1);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst.mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst.mem_write", {31'b0, mem_write}, 32'd0);
    check("rst.mem_addr", {2'b0, mem_addr}, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check("rst.mem_be", {28'b0, mem_be}, 32'd0);
    reset = 1'b0;
    tick();

    run_store("sb13", 2'b00, 32'h13, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000);
    run_store("sb10", 2'b00, 32'h10, 32'h1234_5677, 32'h7777_7777, 4'b0001);
    run_store("sh20", 2'b01, 32'h20, 32'hFFFF_BEEF, 32'hBEEF_BEEF, 4'b0011);
    run_store("sw04", 2'b10, 32'h04, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);

    run_load("lb12", 2'b00, 1'b0, 32'h12, 32'h0080_0000, 32'hFFFF_FF80);
    run_load("lbu12", 2'b00, 1'b1, 32'h12, 32'h0080_0000, 32'h0000_0080);
    run_load("lh22", 2'b01, 1'b0, 32'h22, 32'h8001_1234, 32'hFFFF_8001);
    run_load("lhu20", 2'b01, 1'b1, 32'h20, 32'h0000_F234, 32'h0000_F234);
    run_load("lh20", 2'b01, 1'b0, 32'h20, 32'h0000_F234, 32'hFFFF_F234);
    run_load("lw20", 2'b10, 1'b1, 32'h20, 32'h8001_1234, 32'h8001_1234);
    run_load("lw11", 2'b11, 1'b0, 32'h24, 32'h8765_4321, 32'h8765_4321);

    // Store stalled three cycles in REQ, with a stray mem_rvalid that must be ignored.
    mem_ready = 1'b0;
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_5678);
    mem_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stall.mem_valid", {31'b0, mem_valid}, 32'd1);
      check("stall.mem_addr", {2'b0, mem_addr}, 32'h8);
      check("stall.mem_be", {28'b0, mem_be}, 32'hC);
      check("stall.mem_wdata", mem_wdata, 32'h5678_5678);
      check("stall.req_ready", {31'b0, req_ready}, 32'd0);
      check("stall.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      if (i < 3) tick();
    end
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    tick();
    check("stall.rsp_valid_t5", {31'b0, rsp_valid}, 32'd1);
    tick();

    // Load stalled one cycle in REQ with stray read data: must not complete early.
    mem_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    tick();
    check("lstall.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("lstall.mem_valid", {31'b0, mem_valid}, 32'd1);
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    tick();
    check("lstall.wait", {31'b0, rsp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h2222_3333;
    tick();
    mem_rvalid = 1'b0;
    check("lstall.rsp_valid2", {31'b0, rsp_valid}, 32'd1);
    check("lstall.rsp_rdata", rsp_rdata, 32'h2222_3333);
    tick();

    // Reset while waiting for read data drops the access.
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("rstwait.mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rstwait.req_ready", {31'b0, req_ready}, 32'd1);
    check("rstwait.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    check("rstwait.no_rsp", {31'b0, rsp_valid}, 32'd0);
    check("rstwait.idle", {31'b0, req_ready}, 32'd1);
    run_load("rstwait.lw", 2'b10, 1'b0, 32'h40, 32'hA1B2_C3D4, 32'hA1B2_C3D4);

`ifdef LSU_MISALIGN_TRAP_EN
    mem_ready = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    check("mis.rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("mis.rsp_err", {31'b0, rsp_err}, 32'd1);
    check("mis.rsp_rdata", rsp_rdata, 32'd0);
    check("mis.mem_valid", {31'b0, mem_valid}, 32'd0);
    tick();
    check("mis.mem_valid2", {31'b0, mem_valid}, 32'd0);
    check("mis.ready", {31'b0, req_ready}, 32'd1);
    check("mis.rsp_pulse", {31'b0, rsp_valid}, 32'd0);
`else
    run_load("lw06", 2'b10, 1'b0, 32'h6, 32'hCAFE_BABE, 32'hCAFE_BABE);
    run_load("lh23", 2'b01, 1'b1, 32'h23, 32'h8001_1234, 32'h0000_8001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
